sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_pkg.sv | 11 +
 rtl/debounce_channel.sv | 37 +++
 rtl/sensor_conditioner.sv | 122 ++++++++++++
 tb/tb_sensor_conditioner.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared button FSM state type and default debounce length for the sensor conditioner.
package sensor_pkg;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;  // 10 ms at 50 MHz

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } btn_state_t;
endpackage

// File: rtl/debounce_channel.sv
// One asynchronous level input: 2-flop sync, then DEBOUNCE_CYCLES stable cycles before the level follows.
// Latency 2 + DEBOUNCE_CYCLES edges from a clean raw step; no backpressure, always accepts.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any cycle that agrees with the current level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sensor_conditioner.sv
// Debounces three sensor levels and turns the push-button into a one-cycle press pulse; no backpressure.
// Levels and press pulse lag raw by 2 + DEBOUNCE_CYCLES edges; SENSOR_EVENT_EN enables the sensor_event pulse.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int BUTTON_ACTIVE_LOW = 1
) (
  input  logic clock_50MHz,
  input  logic reset_n,
  input  logic air_umidity_raw,
  input  logic soil_umidity_raw,
  input  logic temperature_raw,
  input  logic button_raw,
  output logic air_umidity,
  output logic soil_umidity,
  output logic temperature,
  output logic button,
  output logic sensor_event
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic BTN_IDLE = (BUTTON_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_air (
    .clk(clock_50MHz), .rst_n(reset_n), .raw(air_umidity_raw), .level(air_umidity)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_soil (
    .clk(clock_50MHz), .rst_n(reset_n), .raw(soil_umidity_raw), .level(soil_umidity)
  );
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_temp (
    .clk(clock_50MHz), .rst_n(reset_n), .raw(temperature_raw), .level(temperature)
  );

  logic [1:0]    btn_sync;
  logic          pressed;
  btn_state_t    btn_state;
  logic [CW-1:0] btn_cnt;

  assign pressed = btn_sync[1] ^ BTN_IDLE;

  // Entering a debounce state already counts the first qualifying cycle, so
  // the press pulse lands exactly DEBOUNCE_CYCLES edges after the sync output.
  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync  <= {2{BTN_IDLE}};
      btn_state <= RELEASED;
      btn_cnt   <= '0;
      button    <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], button_raw};
      button   <= 1'b0;
      case (btn_state)
        RELEASED: begin
          if (pressed) begin
            if (CNT_LAST == '0) begin
              btn_state <= HELD;
              button    <= 1'b1;
            end else begin
              btn_state <= PRESS_DEB;
              btn_cnt   <= CW'(1);
            end
          end
        end
        PRESS_DEB: begin
          if (!pressed) begin
            btn_state <= RELEASED;
            btn_cnt   <= '0;
          end else if (btn_cnt == CNT_LAST) begin
            btn_state <= HELD;
            btn_cnt   <= '0;
            button    <= 1'b1;
          end else begin
            btn_cnt <= btn_cnt + CW'(1);
          end
        end
        HELD: begin
          if (!pressed) begin
            if (CNT_LAST == '0) begin
              btn_state <= RELEASED;
            end else begin
              btn_state <= RELEASE_DEB;
              btn_cnt   <= CW'(1);
            end
          end
        end
        RELEASE_DEB: begin
          if (pressed) begin
            btn_state <= HELD;
            btn_cnt   <= '0;
          end else if (btn_cnt == CNT_LAST) begin
            btn_state <= RELEASED;
            btn_cnt   <= '0;
          end else begin
            btn_cnt <= btn_cnt + CW'(1);
          end
        end
        default: begin
          btn_state <= RELEASED;
          btn_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef SENSOR_EVENT_EN
  logic [2:0] lvl_q;

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= 3'b000;
    end else begin
      lvl_q <= {air_umidity, soil_umidity, temperature};
    end
  end

  // High in the very cycle any debounced level differs from its previous value.
  assign sensor_event = |(lvl_q ^ {air_umidity, soil_umidity, temperature});
`else
  assign sensor_event = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4, active-low button.
`timescale 1ns/1ps
module tb_sensor_conditioner;
  import sensor_pkg::*;

`ifdef SENSOR_EVENT_EN
  localparam logic EV = 1'b1;
`else
  localparam logic EV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic air_raw = 1'b0, soil_raw = 1'b0, temp_raw = 1'b0, btn_raw = 1'b1;
  logic air, soil, temp, btn, sev;
  int checks = 0;
  int errors = 0;

  sensor_conditioner #(.DEBOUNCE_CYCLES(4), .BUTTON_ACTIVE_LOW(1)) dut (
    .clock_50MHz(clk), .reset_n(rst_n),
    .air_umidity_raw(air_raw), .soil_umidity_raw(soil_raw),
    .temperature_raw(temp_raw), .button_raw(btn_raw),
    .air_umidity(air), .soil_umidity(soil), .temperature(temp),
    .button(btn), .sensor_event(sev)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; air_raw = 0; soil_raw = 0; temp_raw = 0; btn_raw = 1;
    repeat (3) tick();
    checks++;
    if ({air, soil, temp, btn, sev} !== 5'b00000) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {air, soil, temp, btn, sev});
    end
    checks++;
    if (dut.btn_state !== RELEASED) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dut.btn_state, RELEASED);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({air, soil, temp, btn, sev} !== 5'b00000) begin
        errors++; $display("FAIL idle_outputs cycle %0d: got %b want 00000", i, {air, soil, temp, btn, sev});
      end
    end
    checks++;
    if (dut.btn_state !== RELEASED) begin
      errors++; $display("FAIL idle_state: got %0d want %0d", dut.btn_state, RELEASED);
    end
  endtask

  task automatic test_sensor_step();
    soil_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (soil !== (i >= 6)) begin
        errors++; $display("FAIL soil_step edge %0d: got %b want %b", i, soil, (i >= 6));
      end
      checks++;
      if (sev !== ((i == 6) & EV)) begin
        errors++; $display("FAIL soil_event edge %0d: got %b want %b", i, sev, ((i == 6) & EV));
      end
      checks++;
      if ({air, temp} !== 2'b00) begin
        errors++; $display("FAIL soil_others edge %0d: got %b want 00", i, {air, temp});
      end
    end
  endtask

  task automatic test_glitch();
    temp_raw = 1'b1;
    repeat (3) tick();
    temp_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({temp, sev} !== 2'b00) begin
        errors++; $display("FAIL glitch cycle %0d: temp/event got %b want 00", i, {temp, sev});
      end
    end
    // Glitch, one low cycle, then a real step: latency counts from the real step.
    temp_raw = 1'b1;
    repeat (3) tick();
    temp_raw = 1'b0;
    tick();
    temp_raw = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (temp !== (i >= 6)) begin
        errors++; $display("FAIL glitch_restart edge %0d: got %b want %b", i, temp, (i >= 6));
      end
      checks++;
      if (sev !== ((i == 6) & EV)) begin
        errors++; $display("FAIL glitch_restart_event edge %0d: got %b want %b", i, sev, ((i == 6) & EV));
      end
    end
  endtask

  task automatic test_button();
    int pulses = 0;
    btn_raw = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (btn === 1'b1) pulses++;
      checks++;
      if (btn !== (i == 6)) begin
        errors++; $display("FAIL press_pulse edge %0d: got %b want %b", i, btn, (i == 6));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL press_count: got %0d want 1", pulses);
    end
    checks++;
    if (dut.btn_state !== HELD) begin
      errors++; $display("FAIL held_state: got %0d want %0d", dut.btn_state, HELD);
    end
    btn_raw = 1'b1;
    repeat (2) tick();
    btn_raw = 1'b0;
    repeat (2) tick();
    btn_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (btn !== 1'b0) begin
        errors++; $display("FAIL release_bounce cycle %0d: got %b want 0", i, btn);
      end
    end
    checks++;
    if (dut.btn_state !== RELEASED) begin
      errors++; $display("FAIL release_state: got %0d want %0d", dut.btn_state, RELEASED);
    end
  endtask

  task automatic test_reset_mid_press();
    btn_raw = 1'b0;
    repeat (4) tick();
    checks++;
    if (dut.btn_state !== PRESS_DEB || dut.btn_cnt !== 3'd2) begin
      errors++; $display("FAIL mid_press: state %0d cnt %0d want %0d cnt 2", dut.btn_state, dut.btn_cnt, PRESS_DEB);
    end
    rst_n = 1'b0; air_raw = 0; soil_raw = 0; temp_raw = 0;
    repeat (2) tick();
    checks++;
    if ({soil, temp, btn} !== 3'b000 || dut.btn_state !== RELEASED) begin
      errors++; $display("FAIL mid_reset: soil/temp/btn %b state %0d want 000 state %0d", {soil, temp, btn}, dut.btn_state, RELEASED);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (btn !== (i == 6)) begin
        errors++; $display("FAIL post_reset_pulse edge %0d: got %b want %b", i, btn, (i == 6));
      end
    end
    btn_raw = 1'b1;
    repeat (10) tick();
    checks++;
    if (dut.btn_state !== RELEASED) begin
      errors++; $display("FAIL post_reset_release: got %0d want %0d", dut.btn_state, RELEASED);
    end
  endtask

  task automatic test_all_sensors();
    logic v;
    for (int pass = 0; pass < 2; pass++) begin
      v = (pass == 0);
      air_raw = v; soil_raw = v; temp_raw = v;
      for (int i = 1; i <= 7; i++) begin
        tick();
        checks++;
        if ({air, soil, temp} !== ((i >= 6) ? {3{v}} : {3{~v}})) begin
          errors++; $display("FAIL all_sensors pass %0d edge %0d: got %b want %b", pass, i, {air, soil, temp}, ((i >= 6) ? {3{v}} : {3{~v}}));
        end
        checks++;
        if (sev !== ((i == 6) & EV)) begin
          errors++; $display("FAIL all_event pass %0d edge %0d: got %b want %b", pass, i, sev, ((i == 6) & EV));
        end
      end
    end
    air_raw = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) temp_raw = 1'b1;
      tick();
      checks++;
      if ({air, soil, temp} !== {(i >= 6), 1'b0, (i >= 8)}) begin
        errors++; $display("FAIL staggered edge %0d: got %b want %b", i, {air, soil, temp}, {(i >= 6), 1'b0, (i >= 8)});
      end
      checks++;
      if (sev !== (((i == 6) || (i == 8)) & EV)) begin
        errors++; $display("FAIL staggered_event edge %0d: got %b want %b", i, sev, (((i == 6) || (i == 8)) & EV));
      end
      checks++;
      if (btn !== 1'b0) begin
        errors++; $display("FAIL staggered_button edge %0d: got %b want 0", i, btn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sensor_step();
    test_glitch();
    test_button();
    test_reset_mid_press();
    test_all_sensors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
